bus_voice_regs: RTL and testbench
=================================

BUS_VOICE_REGS -- requirements
Module: bus_voice_regs

Interface
REQ-001 Parameter: NUM_VOICES, default 4, number of voice register banks (1..15).
REQ-002 Clock  in  1  system clock; all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low.
REQ-004 BusAddress  in  16  byte address; voice v occupies 16'h00v0..16'h00v8, v = 1..NUM_VOICES.
REQ-005 BusData  inout  8  write data from initiator; driven by this block only during a read hit, else 8'hZZ.
REQ-006 BusReadWrite  in  1  1 = write, 0 = read.
REQ-007 BusClock  in  1  asynchronous transfer strobe; transfer occurs on its rising edge.
REQ-008 Gate  out  NUM_VOICES  per-voice gate, bit0 of offset-0 register.
REQ-009 Incr, WaveType, PulseWidth, Attack, Decay, Sustain, Release  out  8*NUM_VOICES each  per-voice registers at offsets 1..7; voice v in bits [8v-1:8v-8].
REQ-010 Linear  out  NUM_VOICES  per-voice envelope mode, bit0 of offset-8 register.
REQ-011 NoteOn, NoteOff  out  NUM_VOICES  one-Clock pulses on Gate 0->1 / 1->0.

Function
REQ-012 BusClock, BusReadWrite, BusAddress, BusData are registered together every Clock into sync stage 1, then stage 2; BusClock also into stage 3.
REQ-013 Transfer event = stage-2 BusClock high and stage-3 low; address/data/RW used are the stage-2 copies.
REQ-014 A BusClock high pulse of at least one Clock period produces exactly one event; pulses shorter than that may be lost.
REQ-015 Write event with address hit: addressed register updated on the event Clock edge; outputs reflect it on the next cycle (3 Clocks after first Clock edge sampling BusClock high).
REQ-016 Offsets 0 and 8 store full 8 bits; only bit0 reaches Gate/Linear; readback returns all 8 stored bits.
REQ-017 Miss (high byte != 0, voice nibble 0 or > NUM_VOICES, offset 9..F): write ignored, no read drive, no state change.
REQ-018 Read: while stage-2 BusClock high, stage-2 RW = 0 and address hit, BusData driven with the addressed register; tri-stated otherwise, incl. the cycle after BusClock low is synchronized.
REQ-019 Register read-mux output is registered; driven value is stable for the whole drive window.
REQ-020 NoteOn[v] pulses one cycle when the write changes Gate[v] 0->1; NoteOff[v] on 1->0; rewriting same value produces no pulse.
REQ-021 Consecutive transfers need only BusClock low for at least one Clock period between them; each handled independently; no backpressure exists.
REQ-022 Only one register changes per event; other voices and offsets untouched.

Reset
REQ-023 Reset low asynchronously clears all registers, sync stages, NoteOn/NoteOff to 0 and releases BusData to 8'hZZ.
REQ-024 Reset asserted mid-transfer aborts it; the first event after release requires a fresh BusClock rising edge (stage 3 resets to 0, so BusClock held high across release yields one event).

Verification
REQ-025 After reset: all outputs 0, BusData = Z; write 16'h0011 = 8'h0F -> Incr[7:0] = 8'h0F three Clocks after strobe, all else 0.
REQ-026 Write 16'h0010 = 8'h01 -> Gate[0] = 1 and one-cycle NoteOn[0]; write 8'h01 again -> no pulse; write 8'h00 -> one-cycle NoteOff[0].
REQ-027 Program voice 2 (16'h0021..16'h0027 = 03,10,00,02,05,7F,05) then read each back with RW = 0 -> BusData returns same values, Z outside drive windows; voice 1 unchanged.
REQ-028 Writes to 16'h0019, 16'h0050 (NUM_VOICES = 4), 16'h0100, 16'h0000 -> no register changes, BusData never driven on reads there.
REQ-029 Strobe 16'h0013 = 8'h3F with Reset pulsed low during stage 1/2 -> PulseWidth stays 0; next normal write 8'h7F lands.
REQ-030 Back-to-back writes, BusClock high 1 Clock / low 1 Clock, 8 registers of voice 1 -> all 8 values land in order, none lost.

Source files
------------

// File: rtl/bus_voice_regs.sv
// Per-voice synthesizer register file behind an asynchronous byte bus.
// The bus strobe and its qualifiers are brought into the Clock domain through
// a two-stage synchronizer. A third strobe stage supplies the rising-edge
// detect. Each voice v (1..NUM_VOICES) owns nine byte registers at
// 16'h00v0..16'h00v8.
module bus_voice_regs #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [15:0]             BusAddress,
  inout  wire  [7:0]              BusData,
  input  logic                    BusReadWrite,
  input  logic                    BusClock,
  output logic [NUM_VOICES-1:0]   Gate,
  output logic [8*NUM_VOICES-1:0] Incr,
  output logic [8*NUM_VOICES-1:0] WaveType,
  output logic [8*NUM_VOICES-1:0] PulseWidth,
  output logic [8*NUM_VOICES-1:0] Attack,
  output logic [8*NUM_VOICES-1:0] Decay,
  output logic [8*NUM_VOICES-1:0] Sustain,
  output logic [8*NUM_VOICES-1:0] Release,
  output logic [NUM_VOICES-1:0]   Linear,
  output logic [NUM_VOICES-1:0]   NoteOn,
  output logic [NUM_VOICES-1:0]   NoteOff
);

  localparam logic [4:0] NV = 5'(NUM_VOICES);

  // A hit needs a zero high byte, a voice nibble in 1..NUM_VOICES and an offset of 0..8.
  function automatic logic addr_hit(input logic [15:0] a);
    return (a[15:8] == 8'h00) && (a[7:4] != 4'h0) &&
           ({1'b0, a[7:4]} <= NV) && (a[3:0] <= 4'd8);
  endfunction

  logic        bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic        rw_s1_q, rw_s2_q;
  logic [15:0] addr_s1_q, addr_s2_q;
  logic [7:0]  data_s1_q, data_s2_q;

  logic [7:0]  regs_q [NUM_VOICES][9];
  logic [7:0]  rdata_d, rdata_q;
  logic [NUM_VOICES-1:0] note_on_d, note_on_q, note_off_d, note_off_q;

  logic [3:0]  voice_s2, offs_s2;
  logic        hit_s2, xfer_ev, wr_ev, rd_en;

  assign voice_s2 = addr_s2_q[7:4];
  assign offs_s2  = addr_s2_q[3:0];
  assign hit_s2   = addr_hit(addr_s2_q);
  assign xfer_ev  = bclk_s2_q & ~bclk_s3_q;
  assign wr_ev    = xfer_ev & rw_s2_q & hit_s2;
  assign rd_en    = bclk_s2_q & ~rw_s2_q & hit_s2;

  // Synchronizer. The whole bus is captured with the strobe so that the
  // stage-2 copies are coherent. Stage 3 exists only for edge detection.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      bclk_s1_q <= BusClock;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      rw_s1_q   <= BusReadWrite;
      rw_s2_q   <= rw_s1_q;
      addr_s1_q <= BusAddress;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= BusData;
      data_s2_q <= data_s1_q;
    end
  end

  // Register file: a single addressed byte is updated per write event.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int v = 0; v < NUM_VOICES; v++)
        for (int o = 0; o < 9; o++)
          regs_q[v][o] <= '0;
    end else if (wr_ev) begin
      for (int v = 0; v < NUM_VOICES; v++)
        for (int o = 0; o < 9; o++)
          if (voice_s2 == 4'(v + 1) && offs_s2 == 4'(o))
            regs_q[v][o] <= data_s2_q;
    end
  end

  // Gate edge detection: compares the incoming bit0 with the stored Gate bit.
  always_comb begin
    note_on_d  = '0;
    note_off_d = '0;
    if (wr_ev && offs_s2 == 4'd0) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_s2 == 4'(v + 1)) begin
          note_on_d[v]  = ~regs_q[v][0][0] &  data_s2_q[0];
          note_off_d[v] =  regs_q[v][0][0] & ~data_s2_q[0];
        end
      end
    end
  end

  // Note pulses are registered so they line up with the Gate change.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      note_on_q  <= '0;
      note_off_q <= '0;
    end else begin
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
    end
  end

  // The read mux is indexed by the stage-1 address. rdata_q therefore
  // already holds the byte for the stage-2 address when the drive window opens.
  always_comb begin
    rdata_d = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      for (int o = 0; o < 9; o++)
        if (addr_s1_q[7:4] == 4'(v + 1) && addr_s1_q[3:0] == 4'(o))
          rdata_d = regs_q[v][o];
  end

  // Registered read data keeps the driven byte glitch-free.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign BusData = rd_en ? rdata_q : 8'hzz;
  assign NoteOn  = note_on_q;
  assign NoteOff = note_off_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign Gate[v]           = regs_q[v][0][0];
    assign Incr[8*v +: 8]       = regs_q[v][1];
    assign WaveType[8*v +: 8]   = regs_q[v][2];
    assign PulseWidth[8*v +: 8] = regs_q[v][3];
    assign Attack[8*v +: 8]     = regs_q[v][4];
    assign Decay[8*v +: 8]      = regs_q[v][5];
    assign Sustain[8*v +: 8]    = regs_q[v][6];
    assign Release[8*v +: 8]    = regs_q[v][7];
    assign Linear[v]         = regs_q[v][8][0];
  end

endmodule

// File: tb/tb_bus_voice_regs.sv
// Testbench for bus_voice_regs: bus writes/reads against a small register model.
module tb_bus_voice_regs;

  localparam int NV = 4;
  localparam logic [7:0] IDLE = 8'hFF;  // value seen on the pulled-up bus when nobody drives

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [15:0]   BusAddress = '0;
  logic          BusReadWrite = 1'b0;
  logic          BusClock = 1'b0;
  wire  [7:0]    BusData;
  logic [7:0]    tb_data = '0;
  logic          tb_drv = 1'b0;
  logic [NV-1:0]   Gate, Linear, NoteOn, NoteOff;
  logic [8*NV-1:0] Incr, WaveType, PulseWidth, Attack, Decay, Sustain, Release;

  assign BusData = tb_drv ? tb_data : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (BusData[i]);
  end

  bus_voice_regs #(.NUM_VOICES(NV)) dut (
    .Clock(Clock), .Reset(Reset), .BusAddress(BusAddress), .BusData(BusData),
    .BusReadWrite(BusReadWrite), .BusClock(BusClock), .Gate(Gate), .Incr(Incr),
    .WaveType(WaveType), .PulseWidth(PulseWidth), .Attack(Attack), .Decay(Decay),
    .Sustain(Sustain), .Release(Release), .Linear(Linear), .NoteOn(NoteOn),
    .NoteOff(NoteOff)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rexp;
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mdl [1:NV][0:8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int v = 1; v <= NV; v++)
      for (int o = 0; o <= 8; o++)
        mdl[v][o] = 8'h00;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int v, o;
    v = int'(a[7:4]);
    o = int'(a[3:0]);
    if (a[15:8] == 8'h00 && v >= 1 && v <= NV && o <= 8) mdl[v][o] = d;
  endtask

  function automatic logic [255:0] act_all();
    return {Gate, Incr, WaveType, PulseWidth, Attack, Decay, Sustain, Release, Linear};
  endfunction

  function automatic logic [255:0] exp_all();
    logic [NV-1:0] g, li;
    logic [8*NV-1:0] inc, wt, pw, at, dc, su, re;
    for (int v = 1; v <= NV; v++) begin
      g[v-1]  = mdl[v][0][0];
      li[v-1] = mdl[v][8][0];
      inc[8*(v-1) +: 8] = mdl[v][1];
      wt[8*(v-1) +: 8]  = mdl[v][2];
      pw[8*(v-1) +: 8]  = mdl[v][3];
      at[8*(v-1) +: 8]  = mdl[v][4];
      dc[8*(v-1) +: 8]  = mdl[v][5];
      su[8*(v-1) +: 8]  = mdl[v][6];
      re[8*(v-1) +: 8]  = mdl[v][7];
    end
    return {g, inc, wt, pw, at, dc, su, re, li};
  endfunction

  // Strobe high for one Clock, low for one Clock.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge Clock);
    BusAddress = a; tb_data = d; tb_drv = 1'b1; BusReadWrite = 1'b1; BusClock = 1'b1;
    @(negedge Clock);
    BusClock = 1'b0;
    @(negedge Clock);
    model_write(a, d);
  endtask

  // Strobe high for two Clocks; the bus is sampled before, inside and after the window.
  task automatic bus_read(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] e;
    sb_q.push_back(exp);
    @(negedge Clock);
    tb_drv = 1'b0; BusAddress = a; BusReadWrite = 1'b0; BusClock = 1'b1;
    @(negedge Clock);
    check({name, "_pre"}, BusData, IDLE);
    @(negedge Clock);
    BusClock = 1'b0;
    if (sb_q.size() == 0) begin
      $display("FAIL %s_sb: scoreboard empty", name);
      total++;
    end else begin
      e = sb_q.pop_front();
      check({name, "_data"}, BusData, e);
      @(negedge Clock);
      check({name, "_hold"}, BusData, e);
    end
    @(negedge Clock);
    check({name, "_release"}, BusData, IDLE);
  endtask

  task automatic settle();
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v2_tab[9];
    vec_t miss_tab[5];
    vec_t b2b_tab[8];
    int   cnt;

    v2_tab[0] = '{16'h0021, 8'h03, 8'h03};
    v2_tab[1] = '{16'h0022, 8'h10, 8'h10};
    v2_tab[2] = '{16'h0023, 8'h00, 8'h00};
    v2_tab[3] = '{16'h0024, 8'h02, 8'h02};
    v2_tab[4] = '{16'h0025, 8'h05, 8'h05};
    v2_tab[5] = '{16'h0026, 8'h7F, 8'h7F};
    v2_tab[6] = '{16'h0027, 8'h05, 8'h05};
    v2_tab[7] = '{16'h0030, 8'hA5, 8'hA5};
    v2_tab[8] = '{16'h0038, 8'h5A, 8'h5A};

    miss_tab[0] = '{16'h0019, 8'h33, IDLE};
    miss_tab[1] = '{16'h0050, 8'h33, IDLE};
    miss_tab[2] = '{16'h0100, 8'h33, IDLE};
    miss_tab[3] = '{16'h0000, 8'h33, IDLE};
    miss_tab[4] = '{16'h0110, 8'h33, IDLE};

    for (int i = 0; i < 8; i++)
      b2b_tab[i] = '{16'h0011 + 16'(i), 8'h21 + 8'(i), 8'h21 + 8'(i)};

    model_reset();

    // Reset state
    repeat (3) @(negedge Clock);
    check("reset_outputs", act_all(), '0);
    check("reset_notes", {NoteOn, NoteOff}, '0);
    check("reset_bus", BusData, IDLE);
    Reset = 1'b1;
    @(negedge Clock);
    check("release_outputs", act_all(), '0);

    // Write latency on Incr of voice 1
    @(negedge Clock);
    BusAddress = 16'h0011; tb_data = 8'h0F; tb_drv = 1'b1; BusReadWrite = 1'b1; BusClock = 1'b1;
    @(posedge Clock); #1;
    check("lat_e1", Incr[7:0], 8'h00);
    BusClock = 1'b0;
    @(posedge Clock); #1;
    check("lat_e2", Incr[7:0], 8'h00);
    @(posedge Clock); #1;
    check("lat_e3", Incr[7:0], 8'h0F);
    model_write(16'h0011, 8'h0F);
    check("first_write_all", act_all(), exp_all());

    // Gate / NoteOn / NoteOff
    bus_write(16'h0010, 8'h01);
    @(posedge Clock); #1;
    check("gate_on", {Gate, NoteOn, NoteOff}, {4'b0001, 4'b0001, 4'b0000});
    @(posedge Clock); #1;
    check("noteon_one_cycle", {NoteOn, NoteOff}, 8'h00);
    bus_write(16'h0010, 8'h01);
    @(posedge Clock); #1;
    check("rewrite_no_pulse", {Gate, NoteOn, NoteOff}, {4'b0001, 4'b0000, 4'b0000});
    @(posedge Clock); #1;
    check("rewrite_no_pulse2", {NoteOn, NoteOff}, 8'h00);
    bus_write(16'h0010, 8'h00);
    @(posedge Clock); #1;
    check("gate_off", {Gate, NoteOn, NoteOff}, {4'b0000, 4'b0000, 4'b0001});
    @(posedge Clock); #1;
    check("noteoff_one_cycle", {NoteOn, NoteOff}, 8'h00);

    // Program voice 2/3 from the table and read everything back
    for (int i = 0; i < 9; i++) bus_write(v2_tab[i].addr, v2_tab[i].wdata);
    settle();
    check("voice2_regs", act_all(), exp_all());
    for (int i = 0; i < 9; i++)
      bus_read($sformatf("rd_%04h", v2_tab[i].addr), v2_tab[i].addr, v2_tab[i].rexp);
    bus_read("rd_v1_incr", 16'h0011, 8'h0F);

    // Misses: no state change, no drive
    for (int i = 0; i < 5; i++) bus_write(miss_tab[i].addr, miss_tab[i].wdata);
    settle();
    check("miss_no_change", act_all(), exp_all());
    for (int i = 0; i < 5; i++)
      bus_read($sformatf("miss_%04h", miss_tab[i].addr), miss_tab[i].addr, miss_tab[i].rexp);

    // Back-to-back writes, strobe 1 high / 1 low
    for (int i = 0; i < 8; i++) bus_write(b2b_tab[i].addr, b2b_tab[i].wdata);
    settle();
    check("b2b_all", act_all(), exp_all());
    for (int i = 0; i < 8; i++)
      bus_read($sformatf("b2b_%04h", b2b_tab[i].addr), b2b_tab[i].addr, b2b_tab[i].rexp);

    // Reset in the middle of a transfer aborts it
    @(negedge Clock);
    BusAddress = 16'h0013; tb_data = 8'h3F; tb_drv = 1'b1; BusReadWrite = 1'b1; BusClock = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1 BusClock = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    repeat (4) @(negedge Clock);
    check("rst_abort_pw", PulseWidth[7:0], 8'h00);
    check("rst_abort_all", act_all(), exp_all());
    bus_write(16'h0013, 8'h7F);
    settle();
    check("post_rst_write", PulseWidth[7:0], 8'h7F);
    check("post_rst_all", act_all(), exp_all());

    // Strobe held high across reset release gives a single event
    @(negedge Clock);
    BusAddress = 16'h0010; tb_data = 8'h01; tb_drv = 1'b1; BusReadWrite = 1'b1; BusClock = 1'b1;
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    model_write(16'h0010, 8'h01);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      if (NoteOn[0]) cnt++;
      if (i == 3) BusClock = 1'b0;
    end
    check("held_high_noteon", 32'(cnt), 32'd1);
    check("held_high_all", act_all(), exp_all());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
